ph_adc_wb: RTL
==============

PH_ADC_WB -- requirements
Module: ph_adc_wb

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25: reset value of DIV, in clk cycles per SCLK half-period.
REQ-002 SHALL have parameter AVG_LOG2, default 3, legal range 0..4: each average covers 2^AVG_LOG2 conversions.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-004 SHALL have ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- wb_adr_i  in  32  Wishbone address; only [3:2] is decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte select; ignored, all accesses are 32-bit.
- wb_ack_o  out  1  acknowledge.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idles low.
- adc_miso  in  1  ADC serial data.
- intr  out  1  new-average interrupt.

Function
REQ-005 SHALL assert wb_ack_o for exactly one cycle, in the cycle after stb&cyc, and SHALL deassert it the next cycle; a held strobe SHALL NOT re-ack until ack has dropped.
REQ-006 SHALL decode the register map:
- 0x0 CTRL (rw): bit0 EN (continuous); bit1 START (write-1, self-clearing, reads 0); bit2 IE.
- 0x4 STATUS: bit0 BUSY (ro); bit1 VALID (ro, cleared by a DATA read); bit2 OVR (write-1-clear).
- 0x8 DATA (ro): [11:0] average; [27:16] last raw sample.
- 0xC DIV (rw): [15:0]; a written 0 SHALL be stored as 1.
REQ-007 SHALL run the FSM IDLE->SETUP->SHIFT->HOLD->IDLE, with each step one half-period of DIV clk cycles:
- SETUP: cs_n low, 1 half-period.
- SHIFT: 32 half-periods, SCLK toggling.
- HOLD: cs_n high, 2 half-periods.
- One conversion = 35*DIV clk cycles.
REQ-008 SHALL sample adc_miso on every SCLK rising edge, MSB first, into a 16-bit shift register; raw sample = captured bits [12:1].
REQ-009 SHALL leave IDLE when EN=1 or on a START pulse, and SHALL set BUSY in every state other than IDLE, and while an average is incomplete.
REQ-010 SHALL accumulate raw samples in a (12+AVG_LOG2)-bit accumulator.
- After 2^AVG_LOG2 conversions: DATA[11:0] = acc >> AVG_LOG2 (truncating), accumulator cleared, VALID set.
- START yields exactly one average, then returns to IDLE unless EN=1.
REQ-011 SHALL set OVR when an average completes while VALID is already 1, and DATA SHALL still be overwritten.
REQ-012 Simultaneous events SHALL resolve as follows:
- Set beats clear for VALID (DATA read vs. new average) and for OVR (W1C vs. new overrun).
- START while BUSY SHALL be ignored.
REQ-013 On EN cleared mid-average, the current conversion SHALL complete, the partial accumulator SHALL be discarded, and the FSM SHALL return to IDLE without setting VALID.
REQ-014 A DIV write SHALL take effect at the next SETUP, never mid-conversion.

Reset
REQ-015 On reset=1 at a clk edge, all state SHALL return to reset values, and any conversion in progress SHALL be aborted.
REQ-016 Reset values SHALL be:
- Outputs: wb_ack_o=0, wb_dat_o=0, adc_cs_n=1, adc_sclk=0, intr=0.
- Registers: CTRL=0, STATUS=0, DATA=0, DIV=CLK_DIV, accumulator=0, FSM=IDLE.

Configuration
REQ-017 With PH_ADC_IRQ_EN defined:
- intr = IE & VALID, registered.
- intr falls one cycle after VALID clears.
REQ-018 Without PH_ADC_IRQ_EN:
- intr SHALL be constant 0.
- CTRL bit2 SHALL read 0 and ignore writes.

Verification
REQ-019 Reset during SHIFT with DIV=2 -> next cycle cs_n=1, sclk=0, BUSY=0, DIV=CLK_DIV.
REQ-020 DIV=2, AVG_LOG2=3, model returns raw 0x5A3, write CTRL=0x2 -> cs_n low exactly 66 clk per conversion, VALID after 560 clk, DATA=0x05A305A3, BUSY=0.
REQ-021 Model raws 0..7 (x0x100) over 8 conversions -> DATA[11:0]=0x380 (truncated mean), DATA[27:16]=0x700.
REQ-022 EN=1, no DATA reads for two averages -> OVR=1; write STATUS=0x4 -> OVR=0; DATA read -> VALID=0.
REQ-023 Write DIV=0 -> readback 1, SCLK period = 2 clk; a DATA read in the same cycle as an average completes leaves VALID=1.
REQ-024 With PH_ADC_IRQ_EN defined, CTRL=0x6 -> intr rises 1 clk after VALID and drops 1 clk after the DATA read ack; without the macro, intr stays 0.

Source files
------------

// File: rtl/ph_adc_wb.sv
// ph_adc_wb: Wishbone-controlled serial ADC front end with block averaging.
// Drives a 3-wire ADC (cs_n/sclk/miso), captures 12-bit raw samples,
// averages 2^AVG_LOG2 conversions and exposes results through four
// 32-bit registers (CTRL, STATUS, DATA, DIV).
// Optional feature macro: PH_ADC_IRQ_EN enables the IE bit and the
// registered new-average interrupt; without it intr is tied low.
module ph_adc_wb #(
  parameter int CLK_DIV  = 25,
  parameter int AVG_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_miso,
  output logic        intr
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int NCONV = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  // Bus-side registers
  logic        ack_q;
  logic [31:0] dat_q;
  logic        en_q;
  logic        valid_q;
  logic        ovr_q;
  logic [15:0] div_q;
  logic        ie_rd;

  // Conversion engine
  state_t      state_q;
  logic [15:0] div_cur_q;
  logic [15:0] cnt_q;
  logic [4:0]  half_q;
  logic        cs_n_q;
  logic        sclk_q;
  logic [15:0] sr_q;

  // Averaging datapath
  logic [ACC_W-1:0] acc_q;
  logic [4:0]       conv_q;
  logic             single_q;
  logic [11:0]      avg_q;
  logic [11:0]      raw_q;

  // Decode and event signals
  logic             wb_req, wr_en, rd_en;
  logic             sel_ctrl, sel_status, sel_data, sel_div;
  logic             busy, start_req, data_rd, ovr_w1c;
  logic             step_end, conv_end, avg_done, cont;
  logic [11:0]      raw_now;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] sum_shifted;
  logic [31:0]      rdata;
  logic             unused_bits;

  // Address bits outside [3:2], byte selects and upper write data carry no meaning
  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:16]};

  // A new request is only accepted once the previous ack has dropped
  assign wb_req     = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_en      = wb_req & wb_we_i;
  assign rd_en      = wb_req & ~wb_we_i;
  assign sel_ctrl   = (wb_adr_i[3:2] == 2'd0);
  assign sel_status = (wb_adr_i[3:2] == 2'd1);
  assign sel_data   = (wb_adr_i[3:2] == 2'd2);
  assign sel_div    = (wb_adr_i[3:2] == 2'd3);

  // BUSY also covers the gap where an average is still being built
  assign busy      = (state_q != S_IDLE) || (conv_q != 5'd0);
  assign start_req = wr_en & sel_ctrl & wb_dat_i[1] & ~busy;
  assign data_rd   = rd_en & sel_data;
  assign ovr_w1c   = wr_en & sel_status & wb_dat_i[2];

  // Step timing: every FSM step is one half-period of div_cur_q cycles
  assign step_end = (cnt_q == div_cur_q - 16'd1);
  assign conv_end = (state_q == S_HOLD) && step_end && (half_q == 5'd1);
  assign raw_now  = sr_q[12:1];
  assign sum      = acc_q + ACC_W'(raw_now);
  assign avg_done = conv_end && (conv_q == 5'(NCONV - 1));
  // A finished average continues only in continuous mode; a partial one
  // continues if either continuous mode or a START-requested average is active
  assign cont     = avg_done ? en_q : (en_q | single_q);

  assign sum_shifted = sum >> AVG_LOG2;

`ifdef PH_ADC_IRQ_EN
  logic ie_q;
  logic intr_q;
  assign ie_rd = ie_q;
  assign intr  = intr_q;

  // Interrupt is a registered copy of IE & VALID
  always_ff @(posedge clk) begin
    if (reset) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= ie_q & valid_q;
    end
  end
`else
  assign ie_rd = 1'b0;
  assign intr  = 1'b0;
`endif

  // Read-data mux, sampled into dat_q when a read is accepted
  always_comb begin
    rdata = 32'h0;
    case (wb_adr_i[3:2])
      2'd0:    rdata = {29'h0, ie_rd, 1'b0, en_q};
      2'd1:    rdata = {29'h0, ovr_q, valid_q, busy};
      2'd2:    rdata = {4'h0, raw_q, 4'h0, avg_q};
      default: rdata = {16'h0, div_q};
    endcase
  end

  // Wishbone handshake and software-visible control/status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'h0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      div_q   <= 16'(CLK_DIV);
`ifdef PH_ADC_IRQ_EN
      ie_q    <= 1'b0;
`endif
    end else begin
      ack_q <= wb_req;
      if (rd_en) begin
        dat_q <= rdata;
      end
      if (wr_en && sel_ctrl) begin
        en_q <= wb_dat_i[0];
`ifdef PH_ADC_IRQ_EN
        ie_q <= wb_dat_i[2];
`endif
      end
      if (wr_en && sel_div) begin
        div_q <= (wb_dat_i[15:0] == 16'h0) ? 16'd1 : wb_dat_i[15:0];
      end
      // A completing average wins over a same-cycle DATA read
      if (avg_done) begin
        valid_q <= 1'b1;
      end else if (data_rd) begin
        valid_q <= 1'b0;
      end
      // A new overrun wins over a same-cycle write-1-clear
      if (avg_done && valid_q) begin
        ovr_q <= 1'b1;
      end else if (ovr_w1c) begin
        ovr_q <= 1'b0;
      end
    end
  end

  // Conversion FSM: IDLE -> SETUP -> SHIFT (32 half-periods) -> HOLD (2) -> IDLE/SETUP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_cur_q <= 16'(CLK_DIV);
      cnt_q     <= 16'h0;
      half_q    <= 5'd0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sr_q      <= 16'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_q || start_req) begin
            state_q   <= S_SETUP;
            cs_n_q    <= 1'b0;
            cnt_q     <= 16'h0;
            div_cur_q <= div_q;
          end
        end
        S_SETUP: begin
          if (step_end) begin
            state_q <= S_SHIFT;
            cnt_q   <= 16'h0;
            half_q  <= 5'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_SHIFT: begin
          if (step_end) begin
            cnt_q  <= 16'h0;
            sclk_q <= ~sclk_q;
            // Capture on the edge where SCLK rises
            if (!sclk_q) begin
              sr_q <= {sr_q[14:0], adc_miso};
            end
            if (half_q == 5'd31) begin
              state_q <= S_HOLD;
              cs_n_q  <= 1'b1;
              sclk_q  <= 1'b0;
              half_q  <= 5'd0;
            end else begin
              half_q <= half_q + 5'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_HOLD: begin
          if (step_end) begin
            cnt_q <= 16'h0;
            if (half_q == 5'd1) begin
              half_q <= 5'd0;
              if (cont) begin
                // Back-to-back conversion; DIV is re-latched here so a
                // register write never disturbs a conversion in flight
                state_q   <= S_SETUP;
                cs_n_q    <= 1'b0;
                div_cur_q <= div_q;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              half_q <= half_q + 5'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
        end
      endcase
    end
  end

  // Averaging: accumulate each raw sample, publish the truncated mean
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      conv_q   <= 5'd0;
      single_q <= 1'b0;
      avg_q    <= 12'h0;
      raw_q    <= 12'h0;
    end else begin
      if (start_req) begin
        single_q <= 1'b1;
      end
      if (conv_end) begin
        raw_q <= raw_now;
        if (avg_done) begin
          avg_q    <= sum_shifted[11:0];
          acc_q    <= '0;
          conv_q   <= 5'd0;
          single_q <= 1'b0;
        end else if (!cont) begin
          // Stopped mid-average: drop the partial sum
          acc_q  <= '0;
          conv_q <= 5'd0;
        end else begin
          acc_q  <= sum;
          conv_q <= conv_q + 5'd1;
        end
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;

endmodule
